multicycle_datapath: RTL and testbench

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath_pkg.sv | 88 ++++++++
 rtl/mc_reg_file.sv | 35 +++
 rtl/multicycle_datapath.sv | 212 +++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_datapath_pkg.sv
// rtl/multicycle_datapath_pkg.sv - shared types and helpers for the multicycle datapath
package multicycle_datapath_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Encoding presented by the external decoder on ALUop
    typedef enum logic [1:0] {
        ALUOP_ADD = 2'd0,
        ALUOP_SUB = 2'd1,
        ALUOP_AND = 2'd2,
        ALUOP_OR  = 2'd3
    } aluop_e;

    // Internal ALU function select
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'd0,
        BR_NE  = 3'd1,
        BR_LT  = 3'd2,
        BR_LE  = 3'd3,
        BR_GT  = 3'd4,
        BR_GE  = 3'd5,
        BR_NV6 = 3'd6,
        BR_NV7 = 3'd7
    } br_cond_e;

    typedef struct packed {
        logic   regwdst;
        logic   alusrc;
        logic   mem2reg;
        logic   regw_en;
        logic   memr;
        logic   memw;
        logic   b;
        logic   jmp;
        logic   hlt;
        logic   imm;
        logic   upd_flag;
        aluop_e aluop;
    } ctrl_t;

    localparam int INSTR_W = 16;

    // Branch target computation always needs an add, whatever ALUop says
    function automatic alu_ctrl_e alu_ctrl_of(input aluop_e op, input logic is_branch);
        alu_ctrl_e c;
        c = ALU_ADD;
        if (!is_branch) begin
            case (op)
                ALUOP_ADD: c = ALU_ADD;
                ALUOP_SUB: c = ALU_SUB;
                ALUOP_AND: c = ALU_AND;
                ALUOP_OR:  c = ALU_OR;
                default:   c = ALU_ADD;
            endcase
        end
        return c;
    endfunction

    function automatic logic branch_taken(input logic [2:0] cond, input logic z, input logic n);
        logic t;
        t = 1'b0;
        case (br_cond_e'(cond))
            BR_EQ:   t = z;
            BR_NE:   t = !z;
            BR_LT:   t = n;
            BR_LE:   t = n | z;
            BR_GT:   t = !n & !z;
            BR_GE:   t = !n;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mc_reg_file.sv
// rtl/mc_reg_file.sv - register file, two async read ports and one sync write port
module mc_reg_file
    import multicycle_datapath_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [2:0]        rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [2:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    // Storage spans the full 3-bit index space; entries at NREGS and above never load
    logic [DATA_W-1:0] regs [8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (int'(wa) < NREGS)) begin
            regs[wa] <= wd;
        end
    end

    assign ra_data = (int'(ra_addr) < NREGS) ? regs[ra_addr] : '0;
    assign rb_data = (int'(rb_addr) < NREGS) ? regs[rb_addr] : '0;

endmodule

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multicycle FETCH/DECODE/EXEC/MEM/WB datapath with single-port memory
module multicycle_datapath
    import multicycle_datapath_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int PC_INC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwdst,
    input  logic              ALUsrc,
    input  logic              mem2reg,
    input  logic              regw_en,
    input  logic              memr,
    input  logic              memw,
    input  logic              b,
    input  logic              jmp,
    input  logic              hlt,
    input  logic              imm,
    input  logic              upd_flag,
    input  logic [1:0]        ALUop,
    output logic [3:0]        opcode,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] pc_current,
    output logic [2:0]        state,
    output logic              retire,
    output logic              halted
);

    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(PC_INC);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q;
    ctrl_t                ctrl_q, ctrl_in;
    logic [DATA_W-1:0]    a_q, b_q, alu_q, ld_q;
    logic                 z_q, n_q;

    logic [DATA_W-1:0]    rd_a, rd_b;
    logic [DATA_W-1:0]    pc_inc, imm_sext, imm_zext, jmp_target;
    logic [DATA_W-1:0]    alu_a, alu_b, alu_res;
    logic                 taken;
    logic                 rf_we;
    logic [2:0]           rf_wa;
    logic [DATA_W-1:0]    rf_wd;

    assign opcode     = instr_q[15:12];
    assign state      = state_q;
    assign halted     = (state_q == ST_HALT);
    assign mem_wdata  = b_q;
    assign pc_inc     = pc_current + PC_STEP;
    assign imm_sext   = {{(DATA_W-6){instr_q[5]}}, instr_q[5:0]};
    assign imm_zext   = {{(DATA_W-9){1'b0}}, instr_q[8:0]};
    assign jmp_target = {pc_inc[DATA_W-1:13], instr_q[11:0], 1'b0};

    always_comb begin
        ctrl_in          = '0;
        ctrl_in.regwdst  = regwdst;
        ctrl_in.alusrc   = ALUsrc;
        ctrl_in.mem2reg  = mem2reg;
        ctrl_in.regw_en  = regw_en;
        ctrl_in.memr     = memr;
        ctrl_in.memw     = memw;
        ctrl_in.b        = b;
        ctrl_in.jmp      = jmp;
        ctrl_in.hlt      = hlt;
        ctrl_in.imm      = imm;
        ctrl_in.upd_flag = upd_flag;
        ctrl_in.aluop    = aluop_e'(ALUop);
    end

    mc_reg_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (instr_q[11:9]),
        .ra_data (rd_a),
        .rb_addr (instr_q[8:6]),
        .rb_data (rd_b),
        .we      (rf_we),
        .wa      (rf_wa),
        .wd      (rf_wd)
    );

    always_comb begin
        alu_a   = ctrl_q.b ? pc_inc : a_q;
        alu_b   = (ctrl_q.b || ctrl_q.alusrc) ? imm_sext : b_q;
        alu_res = '0;
        case (alu_ctrl_of(ctrl_q.aluop, ctrl_q.b))
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            default: alu_res = alu_a + alu_b;
        endcase
        taken = branch_taken(instr_q[11:9], z_q, n_q);
    end

    always_comb begin
        rf_we = (state_q == ST_WB) && ctrl_q.regw_en;
        rf_wa = ctrl_q.imm ? instr_q[11:9] : (ctrl_q.regwdst ? instr_q[5:3] : instr_q[8:6]);
        rf_wd = ctrl_q.imm ? imm_zext : (ctrl_q.mem2reg ? ld_q : alu_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc_current;
        retire   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) state_d = ST_DECODE;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (ctrl_q.hlt) begin
                    state_d = ST_HALT;
                    retire  = 1'b1;
                end else if (ctrl_q.jmp || ctrl_q.b) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else if (ctrl_q.memr || ctrl_q.memw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_we   = ctrl_q.memw;
                mem_addr = alu_q;
                if (mem_ack) begin
                    if (ctrl_q.memw) begin
                        state_d = ST_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_current <= '0;
            instr_q    <= '0;
            ctrl_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            alu_q      <= '0;
            ld_q       <= '0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ack) instr_q <= mem_rdata[INSTR_W-1:0];
                end
                ST_DECODE: begin
                    ctrl_q <= ctrl_in;
                    a_q    <= rd_a;
                    b_q    <= rd_b;
                end
                ST_EXEC: begin
                    alu_q <= alu_res;
                    if (ctrl_q.upd_flag) begin
                        z_q <= (alu_res == '0);
                        n_q <= alu_res[DATA_W-1];
                    end
                    // Branch uses the result being latched into alu_q this same cycle
                    if (!ctrl_q.hlt) begin
                        if (ctrl_q.jmp)    pc_current <= jmp_target;
                        else if (ctrl_q.b) pc_current <= taken ? alu_res : pc_inc;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (ctrl_q.memw) pc_current <= pc_inc;
                        else             ld_q       <= mem_rdata;
                    end
                end
                ST_WB: pc_current <= pc_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - directed self-checking bench for multicycle_datapath
module tb_multicycle_datapath;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16, rst32;
    logic regwdst, alusrc, mem2reg, regw_en, memr, memw, br, jmp, hlt, imm, upd_flag;
    logic [1:0]  aluop;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic [3:0]  opcode16, opcode32;
    logic        mem_req16, mem_we16, retire16, halted16;
    logic        mem_req32, mem_we32, retire32, halted32;
    logic [15:0] mem_addr16, mem_wdata16, pc16;
    logic [31:0] mem_addr32, mem_wdata32, pc32;
    logic [2:0]  state16, state32;

    logic        sel32;
    logic [31:0] v_pc, v_addr, v_wdata;
    logic [3:0]  v_opcode;
    logic [2:0]  v_state;
    logic        v_req, v_we, v_retire, v_halted;

    int n_cmp = 0;
    int n_bad = 0;

    assign v_pc     = sel32 ? pc32        : {16'h0, pc16};
    assign v_addr   = sel32 ? mem_addr32  : {16'h0, mem_addr16};
    assign v_wdata  = sel32 ? mem_wdata32 : {16'h0, mem_wdata16};
    assign v_opcode = sel32 ? opcode32    : opcode16;
    assign v_state  = sel32 ? state32     : state16;
    assign v_req    = sel32 ? mem_req32   : mem_req16;
    assign v_we     = sel32 ? mem_we32    : mem_we16;
    assign v_retire = sel32 ? retire32    : retire16;
    assign v_halted = sel32 ? halted32    : halted16;

    multicycle_datapath #(.DATA_W(16), .NREGS(8), .PC_INC(2)) dut16 (
        .clk(clk), .rst(rst16),
        .regwdst(regwdst), .ALUsrc(alusrc), .mem2reg(mem2reg), .regw_en(regw_en),
        .memr(memr), .memw(memw), .b(br), .jmp(jmp), .hlt(hlt), .imm(imm),
        .upd_flag(upd_flag), .ALUop(aluop), .opcode(opcode16),
        .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16),
        .mem_wdata(mem_wdata16), .mem_rdata(mem_rdata[15:0]), .mem_ack(mem_ack),
        .pc_current(pc16), .state(state16), .retire(retire16), .halted(halted16)
    );

    multicycle_datapath #(.DATA_W(32), .NREGS(6), .PC_INC(2)) dut32 (
        .clk(clk), .rst(rst32),
        .regwdst(regwdst), .ALUsrc(alusrc), .mem2reg(mem2reg), .regw_en(regw_en),
        .memr(memr), .memw(memw), .b(br), .jmp(jmp), .hlt(hlt), .imm(imm),
        .upd_flag(upd_flag), .ALUop(aluop), .opcode(opcode32),
        .mem_req(mem_req32), .mem_we(mem_we32), .mem_addr(mem_addr32),
        .mem_wdata(mem_wdata32), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc_current(pc32), .state(state32), .retire(retire32), .halted(halted32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ctrl(input logic rwd, input logic asrc, input logic m2r, input logic rwe,
                            input logic mr, input logic mw, input logic bb, input logic jj,
                            input logic hh, input logic ii, input logic uf, input logic [1:0] op);
        regwdst = rwd; alusrc = asrc; mem2reg = m2r; regw_en = rwe;
        memr = mr; memw = mw; br = bb; jmp = jj; hlt = hh; imm = ii;
        upd_flag = uf; aluop = op;
    endtask

    // Runs one instruction from FETCH, acting as the memory; called at a negedge in FETCH
    task automatic run_instr(input logic [15:0] instr, input int fwait, input int mwait,
                             input logic [31:0] ld, output int cyc, output int ret,
                             output logic hold_ok, output logic [31:0] maddr,
                             output logic mwe, output logic [31:0] wdata);
        int   fw, mw;
        logic seen, fetched;
        fw = fwait; mw = mwait; cyc = 0; ret = 0; hold_ok = 1'b1;
        seen = 1'b0; fetched = 1'b0; maddr = '0; mwe = 1'b0; wdata = '0;
        do begin
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            if (v_state == 3'd0) begin
                if (fw > 0) fw--;
                else begin
                    mem_ack = 1'b1; mem_rdata = {16'h0, instr}; fetched = 1'b1;
                end
            end else if (v_state == 3'd3) begin
                if (!seen) begin
                    seen = 1'b1; maddr = v_addr; mwe = v_we; wdata = v_wdata;
                end else if (v_addr !== maddr || v_req !== 1'b1 || v_we !== mwe) begin
                    hold_ok = 1'b0;
                end
                if (mw > 0) mw--;
                else begin
                    mem_ack = 1'b1; mem_rdata = ld;
                end
            end
            #1;
            if (v_retire === 1'b1) ret++;
            @(negedge clk);
            cyc++;
        end while ((!fetched || (v_state != 3'd0 && v_state != 3'd5)) && cyc < 40);
        mem_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, ret, bad;
        logic        hold_ok, mwe;
        logic [31:0] maddr, wdata;

        sel32 = 1'b0; rst16 = 1'b1; rst32 = 1'b1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        set_ctrl(0,0,0,0,0,0,0,0,0,0,0,2'd0);
        repeat (2) @(negedge clk);

        chk("rst_state",  {29'h0, v_state}, 32'd0);
        chk("rst_pc",     v_pc, 32'h0);
        chk("rst_req",    {31'h0, v_req}, 32'd1);
        chk("rst_addr",   v_addr, 32'h0);
        chk("rst_retire", {31'h0, v_retire}, 32'd0);
        chk("rst_halted", {31'h0, v_halted}, 32'd0);
        rst16 = 1'b0;

        // li R1,5 ; li R2,3
        set_ctrl(0,0,0,1,0,0,0,0,0,1,0,2'd0);
        run_instr(16'hA205, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("li_cycles", cyc, 4);
        chk("li_opcode", {28'h0, v_opcode}, 32'hA);
        chk("li_pc",     v_pc, 32'h2);
        run_instr(16'hA403, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);

        // add R3 = R1 + R2
        set_ctrl(1,0,0,1,0,0,0,0,0,0,0,2'd0);
        run_instr(16'h0298, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("add_r3",     {16'h0, dut16.u_rf.regs[3]}, 32'd8);
        chk("add_cycles", cyc, 4);
        chk("add_retire", ret, 1);
        chk("add_pc",     v_pc, 32'h6);

        // ld R4, 4(R1) with three wait states in MEM
        set_ctrl(0,1,1,1,1,0,0,0,0,0,0,2'd0);
        run_instr(16'h8304, 0, 3, 32'h1234, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("ld_cycles", cyc, 8);
        chk("ld_hold",   {31'h0, hold_ok}, 32'd1);
        chk("ld_addr",   maddr, 32'h9);
        chk("ld_we",     {31'h0, mwe}, 32'd0);
        chk("ld_r4",     {16'h0, dut16.u_rf.regs[4]}, 32'h1234);
        chk("ld_pc",     v_pc, 32'h8);

        // st R2, 2(R1)
        set_ctrl(0,1,0,0,0,1,0,0,0,0,0,2'd0);
        run_instr(16'h9282, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("st_cycles", cyc, 4);
        chk("st_addr",   maddr, 32'h7);
        chk("st_we",     {31'h0, mwe}, 32'd1);
        chk("st_wdata",  wdata, 32'h3);
        chk("st_retire", ret, 1);
        chk("st_pc",     v_pc, 32'hA);

        // sub R5 = R1 - R1 with flag update: z=1
        set_ctrl(1,0,0,1,0,0,0,0,0,0,1,2'd1);
        run_instr(16'h1268, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("sub_r5", {16'h0, dut16.u_rf.regs[5]}, 32'h0);

        // jmp 0x10
        set_ctrl(0,0,0,0,0,0,0,1,0,0,0,2'd0);
        run_instr(16'hC008, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("jmp_cycles", cyc, 3);
        chk("jmp_pc",     v_pc, 32'h10);

        // beq -2 at 0x10 with z=1 -> taken back to 0x10
        set_ctrl(0,0,0,0,0,0,1,0,0,0,0,2'd0);
        run_instr(16'hB03E, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("beq_t_cycles", cyc, 3);
        chk("beq_t_retire", ret, 1);
        chk("beq_t_pc",     v_pc, 32'h10);

        // add R6 = R1 + R2 with flag update: z=0, then jmp back to 0x10
        set_ctrl(1,0,0,1,0,0,0,0,0,0,1,2'd0);
        run_instr(16'h02B0, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("add_r6", {16'h0, dut16.u_rf.regs[6]}, 32'd8);
        set_ctrl(0,0,0,0,0,0,0,1,0,0,0,2'd0);
        run_instr(16'hC008, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);

        // beq not taken, cond 6 never taken, bne +4 taken
        set_ctrl(0,0,0,0,0,0,1,0,0,0,0,2'd0);
        run_instr(16'hB03E, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("beq_nt_pc", v_pc, 32'h12);
        run_instr(16'hBC3E, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("cond6_pc", v_pc, 32'h14);
        run_instr(16'hB204, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("bne_pc", v_pc, 32'h1A);

        // hlt fetched with two wait states
        set_ctrl(0,0,0,0,0,0,0,0,1,0,0,2'd0);
        run_instr(16'hF000, 2, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("hlt_cycles", cyc, 5);
        chk("hlt_retire", ret, 1);
        chk("hlt_halted", {31'h0, v_halted}, 32'd1);
        chk("hlt_state",  {29'h0, v_state}, 32'd5);
        chk("hlt_pc",     v_pc, 32'h1A);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (v_req !== 1'b0 || v_pc !== 32'h1A || v_halted !== 1'b1) bad++;
        end
        chk("hlt_sticky", bad, 0);

        rst16 = 1'b1;
        #1;
        chk("hlt_rst_r3", {16'h0, dut16.u_rf.regs[3]}, 32'h0);
        @(negedge clk);
        rst16 = 1'b0;
        #1;
        chk("refetch_state", {29'h0, v_state}, 32'd0);
        chk("refetch_req",   {31'h0, v_req}, 32'd1);
        chk("refetch_addr",  v_addr, 32'h0);
        chk("refetch_pc",    v_pc, 32'h0);
        @(negedge clk);

        // Reset asserted mid-cycle during a FETCH wait
        set_ctrl(0,0,0,1,0,0,0,0,0,1,0,2'd0);
        run_instr(16'hA205, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("pre_rst_r1", {16'h0, dut16.u_rf.regs[1]}, 32'd5);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst16 = 1'b1;
        #1;
        chk("arst_state",  {29'h0, v_state}, 32'd0);
        chk("arst_pc",     v_pc, 32'h0);
        chk("arst_addr",   v_addr, 32'h0);
        chk("arst_req",    {31'h0, v_req}, 32'd1);
        chk("arst_retire", {31'h0, v_retire}, 32'd0);
        chk("arst_halted", {31'h0, v_halted}, 32'd0);
        chk("arst_r1",     {16'h0, dut16.u_rf.regs[1]}, 32'h0);

        // 32-bit instance with NREGS=6
        @(negedge clk);
        sel32 = 1'b1;
        rst32 = 1'b0;
        set_ctrl(0,0,0,0,0,0,1,0,0,0,0,2'd0);
        run_instr(16'hB23C, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("w_bne_pc",   v_pc, 32'hFFFF_FFFE);
        chk("w_fetch_addr", v_addr, 32'hFFFF_FFFE);
        set_ctrl(0,1,0,1,0,0,0,0,0,0,0,2'd0);
        run_instr(16'h00FF, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("w_sext_r3",  dut32.u_rf.regs[3], 32'hFFFF_FFFF);
        chk("w_wrap_pc",  v_pc, 32'h0);

        set_ctrl(0,0,0,1,0,0,0,0,0,1,0,2'd0);
        run_instr(16'hAE55, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        run_instr(16'hABFF, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        set_ctrl(0,1,0,0,0,1,0,0,0,0,0,2'd0);
        run_instr(16'h91C0, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("w_r7_ignored", wdata, 32'h0);
        chk("w_st_addr",    maddr, 32'h0);
        run_instr(16'h9140, 0, 0, 32'h0, cyc, ret, hold_ok, maddr, mwe, wdata);
        chk("w_r5_zext", wdata, 32'h1FF);
        chk("w_pc_end",  v_pc, 32'h8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
